// File: rtl/rtc_calendar_if.sv
// Peripheral bus bundle for the RTC/calendar slave.
// Bus semantics: the slave is always ready. A write is accepted on every rising
// clk edge where cs & wr are both high. Reads need no strobe: rdata follows
// addr combinationally and has no side effects.
interface rtc_calendar_if;
    logic        cs;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output cs, wr, addr, wdata, input rdata);
    modport slave  (input cs, wr, addr, wdata, output rdata);
endinterface

// File: rtl/rtc_calendar.sv
// Bus-mapped real-time clock/calendar.
// Programmable prescaler, sec/min/hour/day/month/year with leap-year month
// lengths, h/m/s alarm, write-1-to-clear status flags and a registered level irq.
// Optional feature: define RTC_BCD_EN to add packed-BCD read views of TIME
// (index 6) and DATE (index 7); without it both indices read 0 and no
// conversion logic exists.
module rtc_calendar #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int DIV_W      = 27,
    parameter int YEAR_RESET = 2000
) (
    input  logic          clk,
    input  logic          reset,
    rtc_calendar_if.slave bus,
    output logic          irq
);

    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(CLK_HZ - 1);
    localparam logic [11:0]      YEAR_RST = 12'(YEAR_RESET);

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_TIME   = 3'd1;
    localparam logic [2:0] IDX_DATE   = 3'd2;
    localparam logic [2:0] IDX_ALARM  = 3'd3;
    localparam logic [2:0] IDX_STATUS = 3'd4;
    localparam logic [2:0] IDX_DIV    = 3'd5;
`ifdef RTC_BCD_EN
    localparam logic [2:0] IDX_TBCD   = 3'd6;
    localparam logic [2:0] IDX_DBCD   = 3'd7;
`endif

    // Control and configuration registers
    logic [3:0]       ctrl;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] pcnt;
    logic [5:0]       alm_sec;
    logic [5:0]       alm_min;
    logic [4:0]       alm_hour;

    // Calendar state
    logic [5:0]  sec;
    logic [5:0]  minute;
    logic [4:0]  hour;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;

    // Status and event tracking
    logic alm_flag;
    logic sec_flag;
    logic tick_d;

    logic en, alm_en, irq_en, sec_ie;
    assign en     = ctrl[0];
    assign alm_en = ctrl[1];
    assign irq_en = ctrl[2];
    assign sec_ie = ctrl[3];

    // Bus decode
    logic [2:0] idx;
    logic       wr_en;
    logic       we_ctrl, we_time, we_date, we_alarm, we_status, we_div;

    assign idx       = bus.addr[4:2];
    assign wr_en     = bus.cs & bus.wr;
    assign we_ctrl   = wr_en && (idx == IDX_CTRL);
    assign we_time   = wr_en && (idx == IDX_TIME);
    assign we_date   = wr_en && (idx == IDX_DATE);
    assign we_alarm  = wr_en && (idx == IDX_ALARM);
    assign we_status = wr_en && (idx == IDX_STATUS);
    assign we_div    = wr_en && (idx == IDX_DIV);

    // Address bits outside the register index and unmapped data bits are ignored.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.addr[31:5], bus.addr[1:0], bus.wdata};

    // Month length, with Gregorian leap rule for February; invalid months use 31.
    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [11:0] y);
        logic leap;
        leap = (y[1:0] == 2'b00) &&
               (((y % 12'd100) != 12'd0) || ((y % 12'd400) == 12'd0));
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
            4'd2:                    days_in_month = leap ? 5'd29 : 5'd28;
            default:                 days_in_month = 5'd31;
        endcase
    endfunction

    // Prescaler terminal count reached this cycle
    logic tick;
    assign tick = en && (pcnt == div_r);

    // Carry chain; >= lets out-of-range written values roll over on the next tick
    logic [4:0] dim_cur;
    logic sec_wrap, min_wrap, hour_wrap, day_wrap, month_wrap;
    assign dim_cur    = days_in_month(month, year);
    assign sec_wrap   = (sec >= 6'd59);
    assign min_wrap   = sec_wrap && (minute >= 6'd59);
    assign hour_wrap  = min_wrap && (hour >= 5'd23);
    assign day_wrap   = hour_wrap && (day >= dim_cur);
    assign month_wrap = day_wrap && (month >= 4'd12);

    logic [5:0]  sec_nx, min_nx;
    logic [4:0]  hour_nx, day_nx;
    logic [3:0]  month_nx;
    logic [11:0] year_nx;

    // Incremented calendar values used when a tick is taken
    always_comb begin
        sec_nx   = sec_wrap ? 6'd0 : sec + 6'd1;
        min_nx   = min_wrap ? 6'd0 : (sec_wrap ? minute + 6'd1 : minute);
        hour_nx  = hour_wrap ? 5'd0 : (min_wrap ? hour + 5'd1 : hour);
        day_nx   = day_wrap ? 5'd1 : (hour_wrap ? day + 5'd1 : day);
        month_nx = month_wrap ? 4'd1 : (day_wrap ? month + 4'd1 : month);
        year_nx  = month_wrap ? year + 12'd1 : year;
    end

    // Configuration registers written from the bus
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl     <= 4'd0;
            div_r    <= DIV_RST;
            alm_sec  <= 6'd0;
            alm_min  <= 6'd0;
            alm_hour <= 5'd0;
        end else begin
            if (we_ctrl) ctrl <= bus.wdata[3:0];
            if (we_div)  div_r <= bus.wdata[DIV_W-1:0];
            if (we_alarm) begin
                alm_hour <= bus.wdata[20:16];
                alm_min  <= bus.wdata[13:8];
                alm_sec  <= bus.wdata[5:0];
            end
        end
    end

    // Prescaler: held at 0 while disabled, restarted by any TIME write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
        end else if (!en || we_time || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // TIME register: a bus write beats the tick increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec    <= 6'd0;
            minute <= 6'd0;
            hour   <= 5'd0;
        end else if (we_time) begin
            hour   <= bus.wdata[20:16];
            minute <= bus.wdata[13:8];
            sec    <= bus.wdata[5:0];
        end else if (tick) begin
            sec    <= sec_nx;
            minute <= min_nx;
            hour   <= hour_nx;
        end
    end

    // DATE register: takes the day carry even when TIME is being overwritten
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            day   <= 5'd1;
            month <= 4'd1;
            year  <= YEAR_RST;
        end else if (we_date) begin
            year  <= bus.wdata[27:16];
            month <= bus.wdata[11:8];
            day   <= bus.wdata[4:0];
        end else if (tick) begin
            day   <= day_nx;
            month <= month_nx;
            year  <= year_nx;
        end
    end

    // Marks a cycle whose TIME came from a tick; a TIME write never arms the alarm
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tick_d <= 1'b0;
        else        tick_d <= tick && !we_time;
    end

    logic alarm_hit;
    assign alarm_hit = tick_d && alm_en &&
                       (hour == alm_hour) && (minute == alm_min) && (sec == alm_sec);

    // Status flags: setting takes priority over write-1-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alm_flag <= 1'b0;
            sec_flag <= 1'b0;
        end else begin
            if (alarm_hit)                         alm_flag <= 1'b1;
            else if (we_status && bus.wdata[0])    alm_flag <= 1'b0;
            if (tick)                              sec_flag <= 1'b1;
            else if (we_status && bus.wdata[1])    sec_flag <= 1'b0;
        end
    end

    // Registered level interrupt, one clock behind the flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq <= 1'b0;
        else        irq <= irq_en && (alm_flag || (sec_ie && sec_flag));
    end

`ifdef RTC_BCD_EN
    // Double-dabble conversion of a 12-bit binary value to four BCD digits
    function automatic logic [15:0] bin_to_bcd(input logic [11:0] bin);
        logic [15:0] bcd;
        bcd = 16'd0;
        for (int i = 11; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
            bcd = {bcd[14:0], bin[i]};
        end
        return bcd;
    endfunction

    // Two-digit form; every field other than year stays below 100
    function automatic logic [7:0] bin_to_bcd2(input logic [11:0] bin);
        return 8'(bin_to_bcd(bin));
    endfunction

    logic [31:0] time_bcd;
    logic [31:0] date_bcd;
    assign time_bcd = {8'd0, bin_to_bcd2(12'(hour)), bin_to_bcd2(12'(minute)),
                       bin_to_bcd2(12'(sec))};
    assign date_bcd = {bin_to_bcd(year), bin_to_bcd2(12'(month)), bin_to_bcd2(12'(day))};
`endif

    // Combinational read mux; unmapped bits and indices read 0
    always_comb begin
        bus.rdata = 32'd0;
        case (idx)
            IDX_CTRL:   bus.rdata = {28'd0, ctrl};
            IDX_TIME:   bus.rdata = {11'd0, hour, 2'd0, minute, 2'd0, sec};
            IDX_DATE:   bus.rdata = {4'd0, year, 4'd0, month, 3'd0, day};
            IDX_ALARM:  bus.rdata = {11'd0, alm_hour, 2'd0, alm_min, 2'd0, alm_sec};
            IDX_STATUS: bus.rdata = {30'd0, sec_flag, alm_flag};
            IDX_DIV:    bus.rdata = 32'(div_r);
`ifdef RTC_BCD_EN
            IDX_TBCD:   bus.rdata = time_bcd;
            IDX_DBCD:   bus.rdata = date_bcd;
`endif
            default:    bus.rdata = 32'd0;
        endcase
    end

endmodule
